// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the 3-wire SPI register responder.
//   spi_state_e : frame state encoding
//   RW_READ     : value of the first frame bit that selects a read
//   DEF_ADDR_W  : default address width
//   DEF_DATA_W  : default data width
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_DATA = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } spi_state_e;

  localparam logic RW_READ    = 1'b1;
  localparam int   DEF_ADDR_W = 7;
  localparam int   DEF_DATA_W = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-FF synchronizer for an asynchronous pin, plus single-clk
// rise/fall pulses built from the synchronized level and its previous sample.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous input
//   rise, fall : one-clk edge pulses in the clk domain
// RESET_VAL presets the whole chain, so a pin already sitting at that level
// when reset releases produces no edge.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic meta;
  logic level;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= RESET_VAL;
      level <= RESET_VAL;
      prev  <= RESET_VAL;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/spi_register_slave.sv
// spi_register_slave: 3-wire SPI responder (active-high cs, MSB first, shared
// sdio) in front of a local register bank. All pins are oversampled in the
// clk domain; sclk must be at most clk/8.
// Frame: R/W bit (1 = read), ADDR_W address bits, DATA_W data bits.
//   clk, reset : system clock, synchronous active-high reset
//   sclk, cs   : serial clock (idles low) and chip select from the master
//   sdio       : bidirectional data, driven here only in the read-data phase
//   reg_addr   : address of the current access
//   reg_wdata  : write data, valid with reg_we
//   reg_we     : one-clk write strobe
//   reg_re     : one-clk read request; reg_rdata is sampled the clk after
//   reg_rdata  : read data from the register bank
//   active     : a frame is in progress
//   frame_err  : one-clk pulse when cs drops mid-frame
// Build option SPI_SLAVE_STREAM_EN: after each completed data word the frame
// continues with the next (wrapping) address while cs stays high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a cs rise
// CMD     | shifting in R/W + address bits
// WR_DATA | shifting in write data
// RD_DATA | shifting read data out on sdio
// DONE    | transfer complete, ignore sclk until cs falls
module spi_register_slave #(
  parameter int ADDR_W = spi_pkg::DEF_ADDR_W,
  parameter int DATA_W = spi_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  inout  wire               sdio,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              active,
  output logic              frame_err
);

  import spi_pkg::*;

  localparam int CNT_W = $clog2(1 + ADDR_W + DATA_W + 1);
  localparam int SH_W  = (1 + ADDR_W > DATA_W) ? (1 + ADDR_W) : DATA_W;
  localparam logic [CNT_W-1:0] CMD_BITS   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(1 + ADDR_W + DATA_W);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic sdio_meta, sdio_s;

  spi_state_e        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt, cnt_inc;
  logic [SH_W-1:0]   rx_sh, rx_sh_nxt, rx_shifted;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic              tx_first, tx_first_nxt;
  logic              sdio_oe, sdio_oe_nxt;
  logic [ADDR_W-1:0] reg_addr_nxt;
  logic [DATA_W-1:0] reg_wdata_nxt;
  logic              reg_we_nxt, reg_re_nxt, frame_err_nxt;
  logic              clean_end;
`ifdef SPI_SLAVE_STREAM_EN
  logic              burst, burst_nxt;
`endif

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs chain presets high: if cs is still high when reset releases, no
  // spurious rise is seen and the block waits for a fresh frame.
  spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign sdio   = sdio_oe ? tx_sh[DATA_W-1] : 1'bz;
  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sdio_meta <= 1'b0;
      sdio_s    <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      tx_first  <= 1'b0;
      sdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_SLAVE_STREAM_EN
      burst     <= 1'b0;
`endif
    end else begin
      sdio_meta <= sdio;
      sdio_s    <= sdio_meta;
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_sh_nxt;
      tx_sh     <= tx_sh_nxt;
      tx_first  <= tx_first_nxt;
      sdio_oe   <= sdio_oe_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= reg_re_nxt;
      frame_err <= frame_err_nxt;
`ifdef SPI_SLAVE_STREAM_EN
      burst     <= burst_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_sh_nxt     = rx_sh;
    tx_sh_nxt     = tx_sh;
    tx_first_nxt  = tx_first;
    sdio_oe_nxt   = sdio_oe;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    frame_err_nxt = 1'b0;
    rx_shifted    = {rx_sh[SH_W-2:0], sdio_s};
    cnt_inc       = bit_cnt + 1'b1;
`ifdef SPI_SLAVE_STREAM_EN
    burst_nxt     = burst;
    // Ending a stream exactly on a word boundary is a normal frame end.
    clean_end     = burst && (bit_cnt == CMD_BITS);
`else
    clean_end     = 1'b0;
`endif

    // Register bank answers the clk after reg_re; the first sclk fall is
    // several clks later, so the shifter is always loaded before it drives.
    if (reg_re) tx_sh_nxt = reg_rdata;

    unique case (state)
      IDLE: begin
        if (cs_rise) begin
          state_nxt   = CMD;
          bit_cnt_nxt = '0;
`ifdef SPI_SLAVE_STREAM_EN
          burst_nxt   = 1'b0;
`endif
        end
      end

      CMD: begin
        if (sclk_rise) begin
          rx_sh_nxt   = rx_shifted;
          bit_cnt_nxt = cnt_inc;
          if (cnt_inc == CMD_BITS) begin
            reg_addr_nxt = rx_shifted[ADDR_W-1:0];
            if (rx_shifted[ADDR_W] == RW_READ) begin
              reg_re_nxt   = 1'b1;
              tx_first_nxt = 1'b1;
              state_nxt    = RD_DATA;
            end else begin
              state_nxt = WR_DATA;
            end
          end
        end
      end

      WR_DATA: begin
`ifdef SPI_SLAVE_STREAM_EN
        // Bump the address only after the strobe, so each reg_we carries
        // the address its data belongs to.
        if (reg_we) reg_addr_nxt = reg_addr + 1'b1;
`endif
        if (sclk_rise) begin
          rx_sh_nxt   = rx_shifted;
          bit_cnt_nxt = cnt_inc;
          if (cnt_inc == FRAME_BITS) begin
            reg_wdata_nxt = rx_shifted[DATA_W-1:0];
            reg_we_nxt    = 1'b1;
`ifdef SPI_SLAVE_STREAM_EN
            bit_cnt_nxt   = CMD_BITS;
            burst_nxt     = 1'b1;
`else
            state_nxt     = DONE;
`endif
          end
        end
      end

      RD_DATA: begin
        if (sclk_rise) begin
          bit_cnt_nxt = cnt_inc;
`ifdef SPI_SLAVE_STREAM_EN
          // Fetch the next word now; the following fall presents its MSB
          // without a gap, exactly like the first word after the command.
          if (cnt_inc == FRAME_BITS) begin
            bit_cnt_nxt  = CMD_BITS;
            reg_addr_nxt = reg_addr + 1'b1;
            reg_re_nxt   = 1'b1;
            tx_first_nxt = 1'b1;
            burst_nxt    = 1'b1;
          end
`endif
        end else if (sclk_fall) begin
          if (bit_cnt == FRAME_BITS) begin
            // Master has sampled the last bit; hand the line back.
            sdio_oe_nxt = 1'b0;
            state_nxt   = DONE;
          end else if (tx_first) begin
            sdio_oe_nxt  = 1'b1;
            tx_first_nxt = 1'b0;
          end else begin
            tx_sh_nxt = {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
      end

      DONE: begin
        if (cs_fall) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // cs fall wins over any sclk edge seen in the same clk.
    if (cs_fall && (state == CMD || state == WR_DATA || state == RD_DATA)) begin
      state_nxt     = IDLE;
      sdio_oe_nxt   = 1'b0;
      reg_we_nxt    = 1'b0;
      reg_re_nxt    = 1'b0;
      reg_addr_nxt  = reg_addr;
      reg_wdata_nxt = reg_wdata;
      frame_err_nxt = !clean_end;
    end
  end

endmodule

// File: tb/tb_spi_register_slave.sv
// tb_spi_register_slave: self-checking bench for spi_register_slave.
// A bit-banged SPI master drives frames at clk/16; expected register-side
// events are queued as each frame is issued and compared as the DUT strobes.
// Build with SPI_SLAVE_STREAM_EN defined to exercise streaming.
module tb_spi_register_slave;

  localparam int HALF = 8;
  localparam int EV_WE  = 1;
  localparam int EV_RE  = 2;
  localparam int EV_ERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b0;
  logic       m_oe = 1'b0;
  logic       m_val = 1'b0;
  wire        sdio;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata;
  logic       active, frame_err;

  logic [7:0] mem [128];
  sb_ev_t     sb_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         drive_clks = 0;
  int         contention_clks = 0;

  assign sdio = m_oe ? m_val : 1'bz;
  assign reg_rdata = mem[reg_addr];

  spi_register_slave dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .sdio      (sdio),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .active    (active),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int kind, input logic [31:0] a, input logic [31:0] d);
    sb_ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] a, input logic [31:0] d);
    sb_ev_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_unexpected_event", 32'(kind), 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_kind", 32'(kind), 32'(e.kind));
      check_eq("sb_addr", a, e.addr);
      check_eq("sb_data", d, e.data);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Register bank model behind the DUT.
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (dut.sdio_oe) drive_clks <= drive_clks + 1;
    if (dut.sdio_oe && m_oe) contention_clks <= contention_clks + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_we)    sb_pop(EV_WE, 32'(reg_addr), 32'(reg_wdata));
      if (reg_re)    sb_pop(EV_RE, 32'(reg_addr), 32'd0);
      if (frame_err) sb_pop(EV_ERR, 32'd0, 32'd0);
    end
  end

  // One frame: nw master-driven bits (MSB first) then nr slave-driven bits.
  // stop_at: drop cs after that many bits. rst_at: pulse reset while sclk is
  // high on that bit, then finish the frame without further clocks.
  task automatic spi_xfer(input logic [31:0] wbits, input int nw, input int nr,
                          input int stop_at, input int rst_at,
                          output logic [31:0] rdata);
    bit aborted;
    aborted = 1'b0;
    rdata = '0;
    cs = 1'b1;
    wait_clks(8);
    m_oe = 1'b1;
    for (int i = 0; i < nw + nr; i++) begin
      if (i == stop_at) begin
        aborted = 1'b1;
        break;
      end
      if (i < nw) m_val = wbits[nw-1-i];
      else        m_oe = 1'b0;
      wait_clks(HALF);
      sclk = 1'b1;
      if (i >= nw) rdata = {rdata[30:0], sdio};
      if (i == rst_at) begin
        check_eq("rst_pre_drive", 32'(dut.sdio_oe), 32'd1);
        reset = 1'b1;
        wait_clks(1);
        check_eq("rst_sdio_released", 32'(dut.sdio_oe), 32'd0);
        check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
        check_eq("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check_eq("rst_strobes", {29'd0, reg_we, reg_re, frame_err}, 32'd0);
        check_eq("rst_active", 32'(active), 32'd0);
        wait_clks(2);
        reset = 1'b0;
        sclk = 1'b0;
        break;
      end
      wait_clks(HALF);
      sclk = 1'b0;
    end
    m_oe = 1'b0;
    if (!aborted) wait_clks(HALF);
    cs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          drv0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[5] = 8'hA5;

    wait_clks(5);
    reset = 1'b0;
    wait_clks(1);
    check_eq("reset_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("reset_reg_wdata", 32'(reg_wdata), 32'd0);
    check_eq("reset_strobes", {29'd0, reg_we, reg_re, frame_err}, 32'd0);
    check_eq("reset_active", 32'(active), 32'd0);
    check_eq("reset_sdio", 32'(dut.sdio_oe), 32'd0);

    // Write 0x2A = 0xC3
    drv0 = drive_clks;
    sb_push(EV_WE, 32'h2A, 32'hC3);
    spi_xfer(32'h2AC3, 16, 0, -1, -1, rd);
    wait_clks(16);
    check_eq("wr_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("wr_no_drive", 32'(drive_clks - drv0), 32'd0);

    // Read 0x05 -> 0xA5
    sb_push(EV_RE, 32'h05, 32'd0);
    spi_xfer(32'h85, 8, 8, -1, -1, rd);
    wait_clks(16);
    check_eq("rd_data", rd, 32'h000000A5);
    check_eq("rd_sb_empty", 32'(sb_q.size()), 32'd0);

    // Abort a write after 5 bits
    drv0 = drive_clks;
    sb_push(EV_ERR, 32'd0, 32'd0);
    spi_xfer(32'h2AC3, 16, 0, 5, -1, rd);
    wait_clks(3);
    check_eq("abort_active", 32'(active), 32'd0);
    check_eq("abort_sdio", 32'(dut.sdio_oe), 32'd0);
    wait_clks(16);
    check_eq("abort_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("abort_no_drive", 32'(drive_clks - drv0), 32'd0);

    // Reset during read bit 3, then a normal write
    sb_push(EV_RE, 32'h05, 32'd0);
    spi_xfer(32'h85, 8, 8, -1, 11, rd);
    wait_clks(16);
    check_eq("rst_idle_after", 32'(active), 32'd0);
    sb_push(EV_WE, 32'h33, 32'h5C);
    spi_xfer(32'h335C, 16, 0, -1, -1, rd);
    wait_clks(16);
    check_eq("rst_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back: write 0x10 = 0xFF, 2-sclk gap, read 0x10
    sb_push(EV_WE, 32'h10, 32'hFF);
    spi_xfer(32'h10FF, 16, 0, -1, -1, rd);
    wait_clks(4 * HALF);
    sb_push(EV_RE, 32'h10, 32'd0);
    spi_xfer(32'h90, 8, 8, -1, -1, rd);
    wait_clks(16);
    check_eq("b2b_rd_data", rd, 32'h000000FF);
    check_eq("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

    // Stream: write 0x7F with 16 data bits 0x1234, then read 16 bits back
    sb_push(EV_WE, 32'h7F, 32'h12);
`ifdef SPI_SLAVE_STREAM_EN
    sb_push(EV_WE, 32'h00, 32'h34);
`endif
    drv0 = drive_clks;
    spi_xfer(32'h7F1234, 24, 0, -1, -1, rd);
    wait_clks(16);
    check_eq("stream_wr_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("stream_wr_no_drive", 32'(drive_clks - drv0), 32'd0);

    sb_push(EV_RE, 32'h7F, 32'd0);
`ifdef SPI_SLAVE_STREAM_EN
    sb_push(EV_RE, 32'h00, 32'd0);
    sb_push(EV_RE, 32'h01, 32'd0);
`endif
    spi_xfer(32'hFF, 8, 16, -1, -1, rd);
    wait_clks(16);
    check_eq("stream_rd_word0", 32'(rd[15:8]), 32'h12);
`ifdef SPI_SLAVE_STREAM_EN
    check_eq("stream_rd_word1", 32'(rd[7:0]), 32'h34);
`endif
    check_eq("stream_rd_sb_empty", 32'(sb_q.size()), 32'd0);

    check_eq("contention_clks", 32'(contention_clks), 32'd0);
    check_eq("final_active", 32'(active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
